// File: rtl/snake_engine_if.sv
// Game-side bus for snake_engine: control/apple/pixel inputs from the navigation,
// apple and VGA blocks, and colour/status outputs back to them.
interface snake_engine_if #(
  parameter int H_BITS   = 7,
  parameter int V_BITS   = 6,
  parameter int LEN_BITS = 5
);
  logic                GAME_TICK;
  logic                START;
  logic [1:0]          NAVIGATION_STATE;
  logic [H_BITS-1:0]   APPLE_H;
  logic [V_BITS-1:0]   APPLE_V;
  logic [9:0]          ADDRH;
  logic [8:0]          ADDRV;
  logic [7:0]          COLOUR;
  logic                REACHED_TARGET;
  logic                GAME_OVER;
  logic [LEN_BITS-1:0] LENGTH;

  modport master (
    output GAME_TICK, START, NAVIGATION_STATE, APPLE_H, APPLE_V, ADDRH, ADDRV,
    input  COLOUR, REACHED_TARGET, GAME_OVER, LENGTH
  );

  modport slave (
    input  GAME_TICK, START, NAVIGATION_STATE, APPLE_H, APPLE_V, ADDRH, ADDRV,
    output COLOUR, REACHED_TARGET, GAME_OVER, LENGTH
  );
endinterface

// File: rtl/snake_engine.sv
// Multi-segment snake game engine: moves/grows the body on GAME_TICK, detects self-collision, renders RGB332.
// Latency: body updates on the tick edge, COLOUR is one cycle behind ADDRH/ADDRV; no backpressure, tick-paced.
module snake_engine #(
  parameter int GRID_H     = 80,
  parameter int GRID_V     = 60,
  parameter int H_BITS     = 7,
  parameter int V_BITS     = 6,
  parameter int CELL_SHIFT = 3,
  parameter int MAX_LEN    = 16,
  parameter int INIT_LEN   = 3,
  parameter int LEN_BITS   = 5
) (
  input logic           CLK,
  input logic           RESET_N,
  snake_engine_if.slave bus
);

  typedef struct packed {
    logic [H_BITS-1:0] h;
    logic [V_BITS-1:0] v;
  } cell_t;

  typedef enum logic [1:0] {IDLE, RUN, DEAD} state_t;

  localparam logic [1:0] DIR_R = 2'b00;
  localparam logic [1:0] DIR_D = 2'b01;
  localparam logic [1:0] DIR_U = 2'b10;
  localparam logic [1:0] DIR_L = 2'b11;

  localparam logic [7:0] COL_HEAD = 8'hFF;
  localparam logic [7:0] COL_BODY = 8'hFC;
  localparam logic [7:0] COL_DEAD = 8'hE0;
  localparam logic [7:0] COL_APPL = 8'h07;
  localparam logic [7:0] COL_BKGD = 8'h40;

  state_t              state;
  logic [1:0]          dir;
  cell_t               seg [MAX_LEN];
  logic [LEN_BITS-1:0] length;
  logic [7:0]          colour;
  logic                reached_target;
  logic                game_over;

  logic [1:0] dir_acc;
  cell_t      head_nxt;
  logic       apple_vld, eat, grow, collide;

  logic [9:0] pix_h;
  logic [8:0] pix_v;
  logic       in_grid, hit_head, hit_body, hit_apple;
  logic [7:0] colour_nxt;

  // Straight row along the top edge, head at the right-hand end.
  function automatic cell_t init_seg(int i);
    cell_t c;
    c.h = (i < INIT_LEN) ? H_BITS'(INIT_LEN - 1 - i) : '0;
    c.v = '0;
    return c;
  endfunction

  always_comb begin
    // Encodings are bitwise complements of their opposites, so a reversal is ~dir.
    dir_acc  = (bus.NAVIGATION_STATE == ~dir) ? dir : bus.NAVIGATION_STATE;
    head_nxt = seg[0];
    case (dir_acc)
      DIR_R:   head_nxt.h = (seg[0].h == H_BITS'(GRID_H - 1)) ? '0 : seg[0].h + H_BITS'(1);
      DIR_L:   head_nxt.h = (seg[0].h == '0) ? H_BITS'(GRID_H - 1) : seg[0].h - H_BITS'(1);
      DIR_D:   head_nxt.v = (seg[0].v == V_BITS'(GRID_V - 1)) ? '0 : seg[0].v + V_BITS'(1);
      default: head_nxt.v = (seg[0].v == '0) ? V_BITS'(GRID_V - 1) : seg[0].v - V_BITS'(1);
    endcase

    apple_vld = (int'(bus.APPLE_H) < GRID_H) && (int'(bus.APPLE_V) < GRID_V);
    eat       = apple_vld && (head_nxt.h == bus.APPLE_H) && (head_nxt.v == bus.APPLE_V);
    grow      = eat && (length < LEN_BITS'(MAX_LEN));

    // Without growth the tail cell is vacated this tick, so it is excluded.
    collide = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if ((grow ? (LEN_BITS'(i) < length) : (LEN_BITS'(i + 1) < length)) && (seg[i] == head_nxt))
        collide = 1'b1;
    end
  end

  always_comb begin
    pix_h     = bus.ADDRH >> CELL_SHIFT;
    pix_v     = bus.ADDRV >> CELL_SHIFT;
    in_grid   = (pix_h < 10'(GRID_H)) && (pix_v < 9'(GRID_V));
    hit_head  = (10'(seg[0].h) == pix_h) && (9'(seg[0].v) == pix_v);
    hit_apple = apple_vld && (10'(bus.APPLE_H) == pix_h) && (9'(bus.APPLE_V) == pix_v);
    hit_body  = 1'b0;
    for (int i = 1; i < MAX_LEN; i++) begin
      if ((LEN_BITS'(i) < length) && (10'(seg[i].h) == pix_h) && (9'(seg[i].v) == pix_v))
        hit_body = 1'b1;
    end

    if (!in_grid)       colour_nxt = 8'h00;
    else if (hit_head)  colour_nxt = (state == DEAD) ? COL_DEAD : COL_HEAD;
    else if (hit_body)  colour_nxt = (state == DEAD) ? COL_DEAD : COL_BODY;
    else if (hit_apple) colour_nxt = COL_APPL;
    else                colour_nxt = COL_BKGD;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state          <= IDLE;
      dir            <= DIR_R;
      length         <= LEN_BITS'(INIT_LEN);
      colour         <= 8'h00;
      reached_target <= 1'b0;
      game_over      <= 1'b0;
      for (int i = 0; i < MAX_LEN; i++) seg[i] <= init_seg(i);
    end else begin
      colour         <= colour_nxt;
      reached_target <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.START) state <= RUN;
        end
        RUN: begin
          if (bus.GAME_TICK) begin
            if (collide) begin
              state     <= DEAD;
              game_over <= 1'b1;
            end else begin
              dir    <= dir_acc;
              seg[0] <= head_nxt;
              for (int i = 1; i < MAX_LEN; i++) seg[i] <= seg[i-1];
              if (grow) length <= length + LEN_BITS'(1);
              reached_target <= eat;
            end
          end
        end
        DEAD: begin
          // Direction is reloaded too, so the fresh snake never starts reversed into itself.
          if (bus.START) begin
            state     <= RUN;
            game_over <= 1'b0;
            dir       <= DIR_R;
            length    <= LEN_BITS'(INIT_LEN);
            for (int i = 0; i < MAX_LEN; i++) seg[i] <= init_seg(i);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.COLOUR         = colour;
  assign bus.REACHED_TARGET = reached_target;
  assign bus.GAME_OVER      = game_over;
  assign bus.LENGTH         = length;

endmodule
